// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA raster timing constants and region type
package vga_pkg;

  localparam int CLK_DIV = 2;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACT + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACT + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int SCALE = 5;
  localparam int PIX_W = 7;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } vga_region_e;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position, region decode and scaled index
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACT        = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int SCALE      = 5,
  parameter int CNT_W      = 10,
  parameter int PIX_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_sync,
  output logic             active,
  output logic [PIX_W-1:0] index
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [SUB_W-1:0] sub;
  logic             at_end;
  vga_region_e      region;

  assign at_end  = (count == CNT_W'(TOTAL - 1));
  assign wrap    = en && at_end;
  assign active  = (region == REG_ACTIVE);
  assign in_sync = (region == REG_SYNC);

  always_comb begin
    region = REG_BP;
    if (count < CNT_W'(ACT))
      region = REG_ACTIVE;
    else if (count < CNT_W'(SYNC_START))
      region = REG_FP;
    else if (count <= CNT_W'(SYNC_END))
      region = REG_SYNC;
  end

  // index only steps while the next position is still active, so it holds its
  // last value through blanking and never runs past the image edge
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sub   <= '0;
      index <= '0;
    end else if (en) begin
      if (at_end) begin
        count <= '0;
        sub   <= '0;
        index <= '0;
      end else begin
        count <= count + 1'b1;
        if (count < CNT_W'(ACT - 1)) begin
          if (sub == SUB_W'(SCALE - 1)) begin
            sub   <= '0;
            index <= index + 1'b1;
          end else begin
            sub <= sub + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA HSYNC/VSYNC, blanking and downscaled VRAM coordinates
module vga_timing_gen #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int H_ACT   = vga_pkg::H_ACT,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_ACT   = vga_pkg::V_ACT,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  parameter int SCALE   = vga_pkg::SCALE,
  parameter int PIX_W   = vga_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [PIX_W-1:0] HPIXEL,
  output logic [PIX_W-1:0] VPIXEL,
  output logic             rgb,
  output logic             frame_start
);

  localparam int CNT_W   = vga_pkg::CNT_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             frame_armed;

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_active, v_active;
  logic [PIX_W-1:0] h_index, v_index;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACT(H_ACT), .SYNC_START(H_ACT + H_FP),
    .SYNC_END(H_ACT + H_FP + H_SYNC - 1), .SCALE(SCALE), .CNT_W(CNT_W), .PIX_W(PIX_W)
  ) u_h_axis (
    .clk(clk), .reset(reset), .en(tick), .count(h_count), .wrap(h_wrap),
    .in_sync(h_sync), .active(h_active), .index(h_index)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACT(V_ACT), .SYNC_START(V_ACT + V_FP),
    .SYNC_END(V_ACT + V_FP + V_SYNC - 1), .SCALE(SCALE), .CNT_W(CNT_W), .PIX_W(PIX_W)
  ) u_v_axis (
    .clk(clk), .reset(reset), .en(h_wrap), .count(v_count), .wrap(v_wrap),
    .in_sync(v_sync), .active(v_active), .index(v_index)
  );

  // frame_armed is only set by a real frame wrap, so the (0,0) tick right after
  // reset does not produce a frame_start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      frame_armed <= 1'b0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      rgb         <= 1'b0;
      HPIXEL      <= '0;
      VPIXEL      <= '0;
      frame_start <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (v_wrap)
        frame_armed <= 1'b1;
      else if (tick)
        frame_armed <= 1'b0;
      HSYNC       <= !h_sync;
      VSYNC       <= !v_sync;
      rgb         <= h_active && v_active;
      HPIXEL      <= (h_active && v_active) ? h_index : '0;
      VPIXEL      <= v_active ? v_index : '0;
      frame_start <= tick && frame_armed && (h_count == '0) && (v_count == '0);
    end
  end

endmodule
